adder_job_arbiter: RTL and testbench
====================================

// Module: adder_job_arbiter
// PURPOSE
//  Shares the single Avalon-MM adder peripheral among NUM_REQ requesters. Each requester submits an operand pair.
//  The block grants requesters in round-robin order and sequences the writes p1 -> p2, then waits for done.
//  It returns the sum, tagged with the requester id, on a valid/ready response channel.
//  Sits between the client engines and the adder's Avalon slave port. It is the only master of that port.
// PARAMETERS
//  NUM_REQ         4    number of requesters, 2..8
//  ID_W            2    width of rsp_id, $clog2(NUM_REQ)
//  TIMEOUT_CYCLES  64   WAIT-state watchdog limit (used only with ADDER_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1           clock
//  reset_n         in   1           async active-low reset
//  req_valid       in   NUM_REQ     per-requester job valid
//  req_ready       out  NUM_REQ     one-hot accept pulse
//  req_a           in   NUM_REQ*32  operand A, requester i at [32*i +: 32]
//  req_b           in   NUM_REQ*32  operand B, same packing
//  rsp_valid       out  1           result valid, held until rsp_ready
//  rsp_ready       in   1           consumer accepts result
//  rsp_id          out  ID_W        requester index of the result
//  rsp_sum         out  32          (a+b) mod 2^32
//  rsp_err         out  1           1 = watchdog expired, sum invalid
//  av_write        out  1           to adder write
//  av_address      out  2           to adder address
//  av_writedata    out  32          to adder writedata
//  av_readdata     in   32          from adder readdata
//  av_done         in   1           from adder done
//  busy            out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0 (req_ready, rsp_*, av_*, busy), operand latches 0.
//  FSM: IDLE -> WR_A -> WR_B -> WAIT -> RESP -> IDLE.
//  - IDLE: when any req_valid is set, pick the first set bit searching from rr_ptr+1 with wrap.
//    Drive req_ready[g]=1 combinationally for that one cycle, latch a/b/id, set rr_ptr<=g, go to WR_A.
//  - WR_A: av_write=1, av_address=2'b00, av_writedata=a. Go to WR_B.
//  - WR_B: av_write=1, av_address=2'b01, av_writedata=b. Go to WAIT. The adder clears done on this write.
//  - WAIT: av_write=0. When av_done=1, capture av_readdata into rsp_sum, rsp_err<=0, go to RESP.
//  - RESP: rsp_valid=1. rsp_id/rsp_sum/rsp_err stay stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
//    rsp_valid drops the next cycle.
//  Latency: accept cycle T. Adder writes at T+1 and T+2; done is seen at T+4; rsp_valid is high from T+5.
//  Throughput: one job per 6 cycles when rsp_ready is held high.
//  Requesters must hold req_valid/req_a/req_b stable until req_ready. Dropping req_valid before grant is legal.
//  Simultaneous requests: exactly one grant per IDLE cycle, strict round-robin, so no starvation.
//  New req_valid during WR_A..RESP is not accepted; it waits for IDLE.
//  av_address 2'b10/2'b11 is never driven. av_writedata=0 when av_write=0.
//  Sum wraps mod 2^32; no carry-out is reported.
//  Reset mid-operation: in-flight job is discarded with no response. The requester must resubmit.
// CONFIGURATION
//  Macro ADDER_ARB_TIMEOUT_EN:
//  - Defined: a counter clears on WAIT entry and increments each WAIT cycle. At TIMEOUT_CYCLES without av_done:
//    rsp_sum<=0, rsp_err<=1, go to RESP.
//  - Not defined: no counter; WAIT waits on av_done forever; rsp_err is tied to 0.
// STRUCTURE
//  Package adder_arb_pkg:
//  - state enum {IDLE, WR_A, WR_B, WAIT, RESP}
//  - ADDR_P1=2'b00, ADDR_P2=2'b01
//  Sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr; outputs one-hot grant, grant index, any_req.
//  Purely combinational. The pointer register lives in adder_job_arbiter.
// TESTING
//  1 Single job: req0 a=5, b=7 -> av writes (00,5) then (01,7); rsp_valid at T+5 with id=0, sum=12, err=0.
//  2 Wrap: a=32'hFFFF_FFFF, b=1 -> rsp_sum=0. Then a=32'h8000_0000, b=32'h8000_0000 -> rsp_sum=0.
//  3 Fairness: all 4 req_valid held high with 8 jobs -> grant order 0,1,2,3,0,1,2,3. Each rsp_id matches its grant.
//  4 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/id/sum stable, no av_write, busy=1.
//    Release -> next grant follows.
//  5 Reset mid-job: assert reset_n=0 during WAIT -> all outputs 0 next cycle; no rsp_valid after release.
//  6 With ADDER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: stub holds av_done=0 -> rsp_valid with err=1, sum=0
//    after 8 WAIT cycles.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
// Shared types and constants for the adder job arbiter.
//   state_t  : arbiter sequencing states
//   ADDR_P1  : adder register address of operand A
//   ADDR_P2  : adder register address of operand B (writing it starts the add)
// ---------------------------------------------------------------------------
package adder_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ADDR_P1 = 2'b00;
    localparam logic [1:0] ADDR_P2 = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches req starting one position after
// rr_ptr, wrapping, and reports the first set bit. The pointer register is
// owned by the caller.
// Ports:
//   req        in   NUM_REQ  request vector
//   rr_ptr     in   ID_W     index of the most recent grant
//   grant      out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out  ID_W     index of the granted bit
//   any_req    out  1        at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Offsets 1..NUM_REQ visit every requester once, the previous
        // winner last, which is what keeps the order fair.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                 = 1'b1;
                grant[idx[ID_W-1:0]]  = 1'b1;
                grant_idx             = idx[ID_W-1:0];
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/adder_job_arbiter.sv
// ---------------------------------------------------------------------------
// adder_job_arbiter
// Shares one Avalon-MM adder among NUM_REQ requesters. Jobs are granted
// round-robin, operands are written A then B, the block waits for the adder's
// done flag and returns the sum tagged with the requester id.
//
// Build option: define ADDER_ARB_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles; on expiry the response carries rsp_err=1, rsp_sum=0.
// Without it WAIT blocks on av_done indefinitely and rsp_err is constant 0.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          per-requester job handshake (ready one-hot)
//   req_a/req_b                  operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_ready          result handshake
//   rsp_id/rsp_sum/rsp_err       result payload
//   av_write/av_address/av_writedata/av_readdata/av_done   adder port
//   busy                         high whenever not IDLE
//
// State table
//   IDLE | waiting for a request; grants one per cycle
//   WR_A | writing operand A to ADDR_P1
//   WR_B | writing operand B to ADDR_P2 (adder clears done here)
//   WAIT | waiting for av_done
//   RESP | holding the result until rsp_ready
// ---------------------------------------------------------------------------
module adder_job_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_err,
    output logic                  av_write,
    output logic [1:0]            av_address,
    output logic [31:0]           av_writedata,
    input  logic [31:0]           av_readdata,
    input  logic                  av_done,
    output logic                  busy
);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [31:0]         b_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_req;
    logic [31:0]         a_sel;
    logic [31:0]         b_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

    // One-hot operand mux keyed by the grant vector.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[32*i +: 32];
                b_sel = req_b[32*i +: 32];
            end
        end
    end

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            b_q          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_sum      <= '0;
            av_write     <= 1'b0;
            av_address   <= '0;
            av_writedata <= '0;
            busy         <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        b_q          <= b_sel;
                        rsp_id       <= grant_idx;
                        rr_ptr       <= grant_idx;
                        av_write     <= 1'b1;
                        av_address   <= ADDR_P1;
                        av_writedata <= a_sel;
                        busy         <= 1'b1;
                        state        <= WR_A;
                    end
                end
                WR_A: begin
                    av_address   <= ADDR_P2;
                    av_writedata <= b_q;
                    state        <= WR_B;
                end
                WR_B: begin
                    av_write     <= 1'b0;
                    av_address   <= '0;
                    av_writedata <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                    state        <= WAIT;
                end
                WAIT: begin
                    if (av_done) begin
                        rsp_sum   <= av_readdata;
                        rsp_valid <= 1'b1;
`ifdef ADDER_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef ADDER_ARB_TIMEOUT_EN
                    // The count reaches TIMEOUT_CYCLES-1 on the last allowed WAIT cycle.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_sum   <= '0;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_job_arbiter
// Scoreboard bench: every grant pushes the expected adder writes and the
// expected response; monitors on the falling edge pop and compare them.
// A small adder stub models the Avalon peripheral (done two cycles after the
// operand B write). Define ADDER_ARB_TIMEOUT_EN to include the watchdog case.
// ---------------------------------------------------------------------------
module tb_adder_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_err;
    logic                  av_write;
    logic [1:0]            av_address;
    logic [31:0]           av_writedata;
    logic [31:0]           av_readdata;
    logic                  av_done;
    logic                  busy;

    adder_job_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_err      (rsp_err),
        .av_write     (av_write),
        .av_address   (av_address),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .av_done      (av_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- adder stub ----------------
    logic        stub_hang;
    logic [31:0] p1, p2;
    logic        pend;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_done     <= 1'b0;
            av_readdata <= '0;
            p1          <= '0;
            p2          <= '0;
            pend        <= 1'b0;
        end else begin
            if (av_write && av_address == 2'b00) p1 <= av_writedata;
            if (av_write && av_address == 2'b01) begin
                p2      <= av_writedata;
                av_done <= 1'b0;
                pend    <= !stub_hang;
            end else if (pend) begin
                av_done     <= 1'b1;
                av_readdata <= p1 + p2;
                pend        <= 1'b0;
            end
        end
    end

    // ---------------- requesters ----------------
    logic [31:0] job_a [NUM_REQ][16];
    logic [31:0] job_b [NUM_REQ][16];
    int          job_n [NUM_REQ];
    int          job_i [NUM_REQ];
    bit          acc_flag [NUM_REQ];

    task automatic update_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (job_i[i] < job_n[i]) begin
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = job_a[i][job_i[i]];
                req_b[32*i +: 32]  = job_b[i][job_i[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_a[32*i +: 32]  = '0;
                req_b[32*i +: 32]  = '0;
            end
        end
    endtask

    task automatic add_job(input int r, input logic [31:0] a, input logic [31:0] b);
        job_a[r][job_n[r]] = a;
        job_b[r][job_n[r]] = b;
        job_n[r]++;
        update_drive();
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                job_i[i]++;
            end
        end
        update_drive();
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        err;
        int          lat;
        int          t_acc;
    } exp_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wq[$];
    int   gorder[$];
    int   m_ptr;
    bit   fair_phase;
    int   last_g_cyc;
    bit   rsp_prev;
    exp_t e;
    wr_t  w;
    int   g;

    function automatic int model_pick();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j = (m_ptr + k) % NUM_REQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            rsp_prev = 1'b0;
        end else begin
            if (!av_write) check("wdata_zero_idle", av_writedata, 0);
            else if (wq.size() == 0) check("av_write_unexpected", av_write, 0);
            else begin
                w = wq.pop_front();
                check("av_address", av_address, w.addr);
                check("av_writedata", av_writedata, w.data);
            end

            if (|req_ready) begin
                g = model_pick();
                if (g < 0) check("grant_unexpected", req_ready, 0);
                else begin
                    check("grant", req_ready, 64'd1 << g);
                    if (fair_phase && last_g_cyc >= 0) check("grant_interval", cyc - last_g_cyc, 6);
                    last_g_cyc = cyc;
                    gorder.push_back(g);
                    e.id    = g;
                    e.sum   = stub_hang ? 32'd0 : job_a[g][job_i[g]] + job_b[g][job_i[g]];
                    e.err   = stub_hang;
                    e.lat   = stub_hang ? 11 : 5;
                    e.t_acc = cyc;
                    exp_q.push_back(e);
                    w.addr = 2'b00; w.data = job_a[g][job_i[g]]; wq.push_back(w);
                    w.addr = 2'b01; w.data = job_b[g][job_i[g]]; wq.push_back(w);
                    acc_flag[g] = 1'b1;
                    m_ptr = g;
                end
            end

            if (rsp_valid && !rsp_prev) begin
                if (exp_q.size() > 0) check("latency", cyc - exp_q[0].t_acc, exp_q[0].lat);
                else check("rsp_unexpected", rsp_valid, 0);
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_sum", rsp_sum, e.sum);
                check("rsp_err", rsp_err, e.err);
            end
            rsp_prev = rsp_valid;
        end
    end

    // ---------------- helpers ----------------
    function automatic bit drained();
        for (int i = 0; i < NUM_REQ; i++)
            if (job_i[i] < job_n[i]) return 1'b0;
        return (exp_q.size() == 0) && !busy && !rsp_valid;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        bit ok;
        do begin
            sync();
            n++;
            ok = drained();
        end while (!ok && n < max);
        check("drain", ok, 1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_req_ready"},    req_ready,    0);
        check({pfx, "_rsp_valid"},    rsp_valid,    0);
        check({pfx, "_rsp_id"},       rsp_id,       0);
        check({pfx, "_rsp_sum"},      rsp_sum,      0);
        check({pfx, "_rsp_err"},      rsp_err,      0);
        check({pfx, "_av_write"},     av_write,     0);
        check({pfx, "_av_address"},   av_address,   0);
        check({pfx, "_av_writedata"}, av_writedata, 0);
        check({pfx, "_busy"},         busy,         0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int seen;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        stub_hang  = 1'b0;
        m_ptr      = NUM_REQ - 1;
        fair_phase = 1'b0;
        last_g_cyc = -1;
        rsp_prev   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            job_n[i] = 0;
            job_i[i] = 0;
            acc_flag[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        sync();
        reset_n = 1'b1;

        // single job
        sync();
        add_job(0, 32'd5, 32'd7);
        wait_drain(40);

        // wrap-around sums; requesters 2 then 3 leave the pointer at 3
        add_job(2, 32'hFFFF_FFFF, 32'd1);
        wait_drain(40);
        add_job(3, 32'h8000_0000, 32'h8000_0000);
        wait_drain(40);

        // fairness with all requesters loaded
        gorder.delete();
        fair_phase = 1'b1;
        last_g_cyc = -1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                add_job(i, 32'h1000 * (i + 1) + r, 32'h0300_0000 + 32'(r * 17 + i));
        wait_drain(200);
        fair_phase = 1'b0;
        check("fair_count", gorder.size(), 8);
        for (int k = 0; k < gorder.size() && k < 8; k++)
            check("fair_order", gorder[k], k % NUM_REQ);

        // backpressure
        sync();
        rsp_ready = 1'b0;
        add_job(1, 32'd100, 32'd23);
        add_job(2, 32'd9, 32'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_rsp_sum", rsp_sum, 123);
            check("bp_av_write", av_write, 0);
            check("bp_busy", busy, 1);
            check("bp_req_ready", req_ready, 0);
        end
        sync();
        rsp_ready = 1'b1;
        wait_drain(60);

        // reset during WAIT
        gorder.delete();
        add_job(0, 32'd1, 32'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 20);
        check("rst_grant_seen", req_ready[0], 1);
        repeat (3) @(negedge clk);
        check("rst_in_wait_busy", busy, 1);
        check("rst_in_wait_write", av_write, 0);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        wq.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_flag[i] = 1'b0;
            job_i[i] = job_n[i];
        end
        m_ptr = NUM_REQ - 1;
        update_drive();
        @(negedge clk);
        check_outputs_zero("midreset");
        sync();
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);

        // resubmission; pointer is back at NUM_REQ-1 so requester 0 wins first
        sync();
        gorder.delete();
        add_job(2, 32'd40, 32'd2);
        add_job(0, 32'd1, 32'd2);
        wait_drain(60);
        check("post_reset_count", gorder.size(), 2);
        if (gorder.size() == 2) begin
            check("post_reset_first", gorder[0], 0);
            check("post_reset_second", gorder[1], 2);
        end

`ifdef ADDER_ARB_TIMEOUT_EN
        // watchdog: adder never signals done
        sync();
        stub_hang = 1'b1;
        add_job(1, 32'd3, 32'd4);
        wait_drain(60);
        stub_hang = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
